// File: rtl/placar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : placar_pkg
//  Description : Shared constants for the scoreboard digit datapath.
//                Holds the packer state encoding and the largest legal
//                BCD digit value.
//  Revision    : 1.0  initial release
// ============================================================================
package placar_pkg;

    // Packer state encoding (single bit: collecting / holding a word)
    localparam logic [0:0] COLETA  = 1'b0;
    localparam logic [0:0] CHEIO   = 1'b1;

    // Largest value a BCD digit may legally take
    localparam int         BCD_MAX = 9;

endpackage : placar_pkg
`default_nettype wire

// File: rtl/empacotar_digitos.sv
`default_nettype none
// ============================================================================
//  Module      : empacotar_digitos
//  Description : Packs N_DIG digits of W bits each into one registered word.
//                The first digit accepted lands in slot 0 (LSBs). Once the
//                word is complete it is held with out_valid until the
//                consumer takes it; no digit is accepted while it is held.
//                limpar discards a partially collected word.
//  Options     : `define EMPACOTAR_BCD_CHECK_EN to flag words that contain a
//                digit above 9 (reported on erro with out_valid). Without it,
//                erro is tied low and no compare logic exists.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_DIG      digits per output word (2..8)
//    W          bits per digit (>= 4 when the BCD check is enabled)
//  Ports
//    clk        in   rising-edge clock
//    reset      in   synchronous active-high reset
//    dig_in     in   [W]        digit offered
//    dig_valid  in   dig_in valid this cycle
//    dig_ready  out  block accepts a digit this cycle
//    limpar     in   discard the partial word (ignored while a word is held)
//    saida      out  [N_DIG*W]  packed word, registered
//    out_valid  out  saida holds a complete word
//    out_ready  in   consumer accepts saida this cycle
//    erro       out  held word contains a non-BCD digit
// ============================================================================
module empacotar_digitos
    import placar_pkg::*;
#(
    parameter int N_DIG = 2,
    parameter int W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       dig_in,
    input  logic               dig_valid,
    output logic               dig_ready,
    input  logic               limpar,
    output logic [N_DIG*W-1:0] saida,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               erro
);

    localparam int CW = $clog2(N_DIG + 1);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;

    // Ready depends only on the state register, never on the inputs.
    assign dig_ready = (r_state == COLETA);

    // ------------------------------------------------------------------------
    // Parameter sanity checks (elaboration time)
    // ------------------------------------------------------------------------
    if (N_DIG < 2 || N_DIG > 8) begin : g_ndig_range_bad
        $error("empacotar_digitos: N_DIG must be in 2..8");
    end

    // ------------------------------------------------------------------------
    // Collect / hold state machine and word register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= COLETA;
            r_cnt     <= '0;
            saida     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                COLETA: begin
                    // limpar wins over a simultaneous digit
                    if (limpar) begin
                        r_cnt <= '0;
                        saida <= '0;
                    end else if (dig_valid) begin
                        // Constant-index slot decode keeps the part-selects static
                        for (int k = 0; k < N_DIG; k++) begin
                            if (r_cnt == CW'(k)) begin
                                saida[k*W +: W] <= dig_in;
                            end
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(N_DIG - 1)) begin
                            r_state   <= CHEIO;
                            out_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Word held; slots keep their old contents after hand-off
                    // until the next word overwrites them one by one.
                    if (out_ready) begin
                        r_state   <= COLETA;
                        out_valid <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional BCD range check
    // ------------------------------------------------------------------------
`ifdef EMPACOTAR_BCD_CHECK_EN
    if (W < 4) begin : g_bcd_width_bad
        $error("empacotar_digitos: BCD check needs W >= 4");
    end

    logic r_err;

    // Sticky over one word: set by any accepted digit above 9, cleared when
    // the word is handed off or discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (r_state == COLETA) begin
            if (limpar) begin
                r_err <= 1'b0;
            end else if (dig_valid && (dig_in > W'(BCD_MAX))) begin
                r_err <= 1'b1;
            end
        end else if (out_ready) begin
            r_err <= 1'b0;
        end
    end

    assign erro = r_err & out_valid;
`else
    assign erro = 1'b0;
`endif

endmodule : empacotar_digitos
`default_nettype wire

// File: tb/tb_empacotar_digitos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_empacotar_digitos
//  Description : Self-checking bench for empacotar_digitos. Instance 0 uses
//                N_DIG=2, instance 1 uses N_DIG=4. A word-level model checks
//                every output of both instances each cycle; literal checks
//                pin the model on hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_empacotar_digitos;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dv, lim, ordy;
    logic [3:0]  din [2];
    logic [1:0]  rdy, ov, er;
    logic [7:0]  saida0;
    logic [15:0] saida1;

    always #5 clk = ~clk;

    empacotar_digitos #(.N_DIG(2), .W(4)) u_dut0 (
        .clk(clk), .reset(rst), .dig_in(din[0]), .dig_valid(dv[0]),
        .dig_ready(rdy[0]), .limpar(lim[0]), .saida(saida0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .erro(er[0])
    );

    empacotar_digitos #(.N_DIG(4), .W(4)) u_dut1 (
        .clk(clk), .reset(rst), .dig_in(din[1]), .dig_valid(dv[1]),
        .dig_ready(rdy[1]), .limpar(lim[1]), .saida(saida1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .erro(er[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- word-level model ----------------
    int m_n    [2];      // digits collected into the current word
    int m_slot [2][8];   // digit value held in each slot
    bit m_full [2];      // complete word waiting for the consumer
    bit m_bad  [2];      // current word has a digit above 9

    function automatic int ndig(int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_word(int i);
        logic [31:0] s = 0;
        for (int k = 0; k < ndig(i); k++) s = s + (m_slot[i][k] << (4 * k));
        return s;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_n[i] = 0; m_full[i] = 0; m_bad[i] = 0;
                for (int k = 0; k < 8; k++) m_slot[i][k] = 0;
            end else if (!m_full[i]) begin
                if (lim[i]) begin
                    m_n[i] = 0; m_bad[i] = 0;
                    for (int k = 0; k < 8; k++) m_slot[i][k] = 0;
                end else if (dv[i]) begin
                    m_slot[i][m_n[i]] = int'(din[i]);
                    if (din[i] > 9) m_bad[i] = 1;
                    m_n[i]++;
                    if (m_n[i] == ndig(i)) m_full[i] = 1;
                end
            end else if (ordy[i]) begin
                m_full[i] = 0; m_n[i] = 0; m_bad[i] = 0;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: model follows the edge, then all outputs are compared.
    task automatic step();
        logic exp_err;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
`ifdef EMPACOTAR_BCD_CHECK_EN
            exp_err = m_bad[i] && m_full[i];
`else
            exp_err = 1'b0;
`endif
            check($sformatf("u%0d.dig_ready", i), 32'(rdy[i]), 32'(!m_full[i]));
            check($sformatf("u%0d.out_valid", i), 32'(ov[i]),  32'(m_full[i]));
            check($sformatf("u%0d.erro", i),      32'(er[i]),  32'(exp_err));
            check($sformatf("u%0d.saida", i),
                  (i == 0) ? 32'(saida0) : 32'(saida1), m_word(i));
        end
    endtask

    task automatic put(int i, logic [3:0] d);
        dv[i] = 1'b1; din[i] = d;
        step();
        dv[i] = 1'b0;
    endtask

    int          sent[$];
    int          nxt, words, last_cyc;
    logic [7:0]  w_exp;

    initial begin
        rst = 1'b1; dv = '0; lim = '0; ordy = '0; din[0] = '0; din[1] = '0;
        step(); step();
        check("reset.saida0", 32'(saida0), 32'h0);
        check("reset.ready0", 32'(rdy[0]), 32'h1);
        rst = 1'b0;

        // 3 then 7 -> 8'h73 held, not ready
        put(0, 4'd3); put(0, 4'd7);
        check("pair.saida", 32'(saida0), 32'h73);
        check("pair.valid", 32'(ov[0]), 32'h1);
        check("pair.ready", 32'(rdy[0]), 32'h0);

        // held with back-pressure while digits keep arriving
        dv[0] = 1'b1; din[0] = 4'd5;
        repeat (5) step();
        dv[0] = 1'b0;
        check("hold.saida", 32'(saida0), 32'h73);
        ordy[0] = 1'b1; step(); ordy[0] = 1'b0;
        check("handoff.valid", 32'(ov[0]), 32'h0);
        check("handoff.retain", 32'(saida0), 32'h73);
        put(0, 4'd1);
        check("restart.slot0", 32'(saida0), 32'h71);
        put(0, 4'd2);
        check("restart.word", 32'(saida0), 32'h21);
        ordy[0] = 1'b1; step(); ordy[0] = 1'b0;

        // reset while holding a word
        put(0, 4'd3); put(0, 4'd7);
        check("prerst.saida", 32'(saida0), 32'h73);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst.valid", 32'(ov[0]), 32'h0);
        check("midrst.saida", 32'(saida0), 32'h0);
        check("midrst.ready", 32'(rdy[0]), 32'h1);

        // N_DIG=4: limpar beats a simultaneous digit
        put(1, 4'd1); put(1, 4'd2);
        check("part.saida1", 32'(saida1), 32'h0021);
        lim[1] = 1'b1; dv[1] = 1'b1; din[1] = 4'd9;
        step();
        lim[1] = 1'b0; dv[1] = 1'b0;
        check("limpar.saida1", 32'(saida1), 32'h0);
        put(1, 4'd4); put(1, 4'd3); put(1, 4'd2); put(1, 4'd1);
        check("quad.saida1", 32'(saida1), 32'h1234);
        check("quad.valid1", 32'(ov[1]), 32'h1);
        lim[1] = 1'b1; step(); lim[1] = 1'b0;
        check("limpar_held.saida1", 32'(saida1), 32'h1234);
        check("limpar_held.valid1", 32'(ov[1]), 32'h1);
        ordy[1] = 1'b1; step(); ordy[1] = 1'b0;

`ifdef EMPACOTAR_BCD_CHECK_EN
        put(0, 4'd4); put(0, 4'hA);
        check("bcd.valid", 32'(ov[0]), 32'h1);
        check("bcd.erro", 32'(er[0]), 32'h1);
        ordy[0] = 1'b1; step(); ordy[0] = 1'b0;
        put(0, 4'd1); put(0, 4'd2);
        check("bcd_ok.erro", 32'(er[0]), 32'h0);
        ordy[0] = 1'b1; step(); ordy[0] = 1'b0;
`endif

        // back-to-back words with the consumer always ready
        ordy[0] = 1'b1; dv[0] = 1'b1; nxt = 0; words = 0; last_cyc = -1;
        for (int c = 0; c < 30; c++) begin
            din[0] = 4'(nxt % 10);
            if (!m_full[0]) begin
                sent.push_back(nxt % 10);
                nxt++;
            end
            step();
            if (ov[0]) begin
                words++;
                if (sent.size() >= 2) begin
                    w_exp = {4'(sent[1]), 4'(sent[0])};
                    void'(sent.pop_front()); void'(sent.pop_front());
                    check("b2b.word", 32'(saida0), 32'(w_exp));
                end else begin
                    check("b2b.queue", 32'(sent.size()), 32'd2);
                end
                if (last_cyc >= 0) check("b2b.period", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
            end
        end
        dv[0] = 1'b0; ordy[0] = 1'b0;
        check("b2b.words", 32'(words), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_empacotar_digitos
`default_nettype wire
